// File: rtl/tetris_pkg.sv
// Shared definitions for the piece sequencing logic.
//   PIECE_W     : bits per piece code
//   NUM_PIECES  : number of valid piece codes (0..NUM_PIECES-1)
//   PIECE_*     : named piece codes
//   queue_state_e : preview queue state (FILL / FULL)
//   code_in_range : true when a raw code names a real piece
package tetris_pkg;

  localparam int PIECE_W    = 3;
  localparam int NUM_PIECES = 7;

  localparam logic [PIECE_W-1:0] PIECE_I = 3'd0;
  localparam logic [PIECE_W-1:0] PIECE_O = 3'd1;
  localparam logic [PIECE_W-1:0] PIECE_T = 3'd2;
  localparam logic [PIECE_W-1:0] PIECE_S = 3'd3;
  localparam logic [PIECE_W-1:0] PIECE_Z = 3'd4;
  localparam logic [PIECE_W-1:0] PIECE_J = 3'd5;
  localparam logic [PIECE_W-1:0] PIECE_L = 3'd6;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    FULL = 1'b1
  } queue_state_e;

  // Widened compare so NUM_PIECES never truncates against the code width.
  function automatic logic code_in_range(input logic [PIECE_W-1:0] code);
    return ({1'b0, code} < (PIECE_W+1)'(NUM_PIECES));
  endfunction

endpackage

// File: rtl/piece_filter.sv
// Combinational accept/reject of the raw randomizer code.
// Optional feature macro: PIECE_QUEUE_BAG7_EN (bag-of-seven mode).
// Ports:
//   rand_in   in  raw randomizer code
//   mask      in  used-piece mask (bag mode only)
//   next_mask out mask to load if this code is accepted (bag mode only)
//   accept    out code is a valid, drawable piece
module piece_filter
  import tetris_pkg::*;
(
  input  logic [PIECE_W-1:0]    rand_in,
`ifdef PIECE_QUEUE_BAG7_EN
  input  logic [NUM_PIECES-1:0] mask,
  output logic [NUM_PIECES-1:0] next_mask,
`endif
  output logic                  accept
);

`ifdef PIECE_QUEUE_BAG7_EN
  logic [NUM_PIECES-1:0] onehot_s;
  logic [NUM_PIECES-1:0] set_mask_s;

  // Bag rule: reject codes already drawn; a full bag empties on the same accept.
  always_comb begin
    onehot_s   = {NUM_PIECES{1'b0}};
    set_mask_s = mask;
    next_mask  = mask;
    accept     = 1'b0;
    if (code_in_range(rand_in)) begin
      onehot_s = NUM_PIECES'(1) << rand_in;
    end else begin
      onehot_s = {NUM_PIECES{1'b0}};
    end
    accept     = code_in_range(rand_in) && ((mask & onehot_s) == {NUM_PIECES{1'b0}});
    set_mask_s = mask | onehot_s;
    if (&set_mask_s) begin
      next_mask = {NUM_PIECES{1'b0}};
    end else begin
      next_mask = set_mask_s;
    end
  end
`else
  // Plain mode: only out-of-range codes are rejected.
  always_comb begin
    accept = code_in_range(rand_in);
  end
`endif

endmodule

// File: rtl/piece_queue_ctrl.sv
// Preview queue between the piece randomizer and the game FSM.
// Optional feature macro: PIECE_QUEUE_BAG7_EN (bag-of-seven draw rule).
// Ports:
//   clk         in  system clock
//   restart     in  asynchronous active-high reset
//   rand_in     in  raw randomizer code, sampled each posedge
//   next_req    in  pop request, honoured only while next_valid=1
//   next_valid  out head entry present (registered)
//   next_piece  out head piece code (registered)
//   preview     out queue contents, entry 0 in LSBs
//   count       out number of valid entries
//   reroll_cnt  out saturating count of discarded samples
module piece_queue_ctrl
  import tetris_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                     clk,
  input  logic                     restart,
  input  logic [PIECE_W-1:0]       rand_in,
  input  logic                     next_req,
  output logic                     next_valid,
  output logic [PIECE_W-1:0]       next_piece,
  output logic [DEPTH*PIECE_W-1:0] preview,
  output logic [2:0]               count,
  output logic [7:0]               reroll_cnt
);

  logic [PIECE_W-1:0] entry_r     [DEPTH];
  logic [PIECE_W-1:0] shifted_s   [DEPTH];
  logic [PIECE_W-1:0] entry_nxt_s [DEPTH];
  logic [2:0]         count_r;
  logic [2:0]         count_nxt_s;
  logic [2:0]         wr_idx_s;
  queue_state_e       state_r;
  queue_state_e       state_nxt_s;
  logic               next_valid_r;
  logic [7:0]         reroll_r;
  logic [7:0]         reroll_nxt_s;
  logic               accept_s;
  logic               pop_s;
  logic               push_s;
  logic               reject_s;

`ifdef PIECE_QUEUE_BAG7_EN
  logic [NUM_PIECES-1:0] mask_r;
  logic [NUM_PIECES-1:0] filt_mask_s;

  piece_filter u_filter (
    .rand_in   (rand_in),
    .mask      (mask_r),
    .next_mask (filt_mask_s),
    .accept    (accept_s)
  );

  // Used-piece mask advances only on an actual push.
  always_ff @(posedge clk or posedge restart) begin
    if (restart) begin
      mask_r <= {NUM_PIECES{1'b0}};
    end else if (push_s) begin
      mask_r <= filt_mask_s;
    end else begin
      mask_r <= mask_r;
    end
  end
`else
  piece_filter u_filter (
    .rand_in (rand_in),
    .accept  (accept_s)
  );
`endif

  // Handshake qualification: samples only matter while the queue has room.
  always_comb begin
    pop_s    = next_req && next_valid_r;
    push_s   = 1'b0;
    reject_s = 1'b0;
    if (state_r == FILL) begin
      push_s   = accept_s;
      reject_s = !accept_s;
    end else begin
      push_s   = 1'b0;
      reject_s = 1'b0;
    end
  end

  // Next queue contents: shift on pop, then drop the new sample at the tail.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      shifted_s[i] = entry_r[i];
    end
    if (pop_s) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        shifted_s[i] = entry_r[i+1];
      end
      shifted_s[DEPTH-1] = {PIECE_W{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        shifted_s[i] = entry_r[i];
      end
    end
    // A pop has already moved the tail down one slot.
    wr_idx_s = pop_s ? (count_r - 3'd1) : count_r;
    for (int i = 0; i < DEPTH; i++) begin
      entry_nxt_s[i] = (push_s && (3'(i) == wr_idx_s)) ? rand_in : shifted_s[i];
    end
  end

  // Occupancy, queue state and reroll bookkeeping.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + 3'd1;
      2'b01:   count_nxt_s = count_r - 3'd1;
      default: count_nxt_s = count_r;
    endcase

    state_nxt_s = state_r;
    case (state_r)
      FILL:    state_nxt_s = (count_nxt_s == 3'(DEPTH)) ? FULL : FILL;
      FULL:    state_nxt_s = pop_s ? FILL : FULL;
      default: state_nxt_s = FILL;
    endcase

    reroll_nxt_s = reroll_r;
    if (reject_s && (reroll_r != 8'hFF)) begin
      reroll_nxt_s = reroll_r + 8'd1;
    end else begin
      reroll_nxt_s = reroll_r;
    end
  end

  // State register; next_valid is registered from the next count.
  always_ff @(posedge clk or posedge restart) begin
    if (restart) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_r[i] <= {PIECE_W{1'b0}};
      end
      count_r      <= 3'd0;
      state_r      <= FILL;
      next_valid_r <= 1'b0;
      reroll_r     <= 8'd0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_r[i] <= entry_nxt_s[i];
      end
      count_r      <= count_nxt_s;
      state_r      <= state_nxt_s;
      next_valid_r <= (count_nxt_s != 3'd0);
      reroll_r     <= reroll_nxt_s;
    end
  end

  assign next_valid = next_valid_r;
  assign next_piece = entry_r[0];
  assign count      = count_r;
  assign reroll_cnt = reroll_r;

  for (genvar g = 0; g < DEPTH; g++) begin : g_preview
    assign preview[g*PIECE_W +: PIECE_W] = entry_r[g];
  end

endmodule

// File: tb/tb_piece_queue_ctrl.sv
// Directed self-checking bench for piece_queue_ctrl (DEPTH=3).
// Bag-mode sequence runs when PIECE_QUEUE_BAG7_EN is defined.
module tb_piece_queue_ctrl;

  logic       clk;
  logic       restart;
  logic [2:0] rand_in;
  logic       next_req;
  logic       next_valid;
  logic [2:0] next_piece;
  logic [8:0] preview;
  logic [2:0] count;
  logic [7:0] reroll_cnt;

  int pass_cnt;
  int total_cnt;

  piece_queue_ctrl #(.DEPTH(3)) dut (
    .clk        (clk),
    .restart    (restart),
    .rand_in    (rand_in),
    .next_req   (next_req),
    .next_valid (next_valid),
    .next_piece (next_piece),
    .preview    (preview),
    .count      (count),
    .reroll_cnt (reroll_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    total_cnt++;
    if (got == exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock edge, then settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_state(input string tag, input int unsigned exp_cnt,
                             input int unsigned exp_prev, input int unsigned exp_rr);
    check({tag, ".count"}, count, exp_cnt);
    check({tag, ".preview"}, preview, exp_prev);
    check({tag, ".reroll"}, reroll_cnt, exp_rr);
    check({tag, ".valid"}, next_valid, (exp_cnt != 0) ? 1 : 0);
    check({tag, ".head"}, next_piece, exp_prev & 7);
  endtask

`ifdef PIECE_QUEUE_BAG7_EN
  logic [2:0] bag_rand [9] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0};
  logic       bag_vld  [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    restart   = 1'b0;
    rand_in   = 3'd7;
    next_req  = 1'b0;
    #1 restart = 1'b1;
    #1;
    check_state("reset", 0, 0, 0);
    #10;  // t=12, clock low
    restart = 1'b0;

`ifdef PIECE_QUEUE_BAG7_EN
    // Continuous popping; duplicate 0 rejected, 8th accept reuses 0.
    next_req = 1'b1;
    for (int i = 0; i < 9; i++) begin
      rand_in = bag_rand[i];
      tick();
      check($sformatf("bag%0d.valid", i), next_valid, bag_vld[i]);
      if (bag_vld[i]) begin
        check($sformatf("bag%0d.head", i), next_piece, bag_rand[i]);
      end else begin
        check($sformatf("bag%0d.count", i), count, 0);
      end
    end
    check("bag.reroll", reroll_cnt, 1);
    next_req = 1'b0;
`else
    // Reset fill: 2,5,1 -> {1,5,2}
    rand_in = 3'd2; tick(); check_state("fill1", 1, 2, 0);
    rand_in = 3'd5; tick(); check_state("fill2", 2, 42, 0);
    rand_in = 3'd1; tick(); check_state("fill3", 3, 106, 0);
    // Invalid code while FULL does nothing
    rand_in = 3'd7; tick(); check_state("full_rej", 3, 106, 0);
    // Pop while FULL: sample ignored this edge, taken the next
    next_req = 1'b1; rand_in = 3'd3; tick(); check_state("full_pop", 2, 13, 0);
    next_req = 1'b0; rand_in = 3'd3; tick(); check_state("refill", 3, 205, 0);
    // Pop from FULL with invalid code: no reroll counted
    next_req = 1'b1; rand_in = 3'd7; tick(); check_state("pop_7", 2, 25, 0);
    // Rejects in FILL
    next_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_state("rej4", 2, 25, 4);
    rand_in = 3'd3; tick(); check_state("rej_acc", 3, 217, 4);
    // Drain
    next_req = 1'b1; rand_in = 3'd7;
    tick(); check_state("drain1", 2, 27, 4);
    tick(); check_state("drain2", 1, 3, 5);
    tick(); check_state("drain3", 0, 0, 6);
    tick(); check_state("pop_empty", 0, 0, 7);
    // Pop and push together
    next_req = 1'b0;
    rand_in = 3'd4; tick();
    rand_in = 3'd6; tick(); check_state("pp_setup", 2, 52, 7);
    next_req = 1'b1; rand_in = 3'd0; tick(); check_state("pop_push", 2, 6, 7);
    // Reroll saturation
    next_req = 1'b0; rand_in = 3'd7;
    for (int i = 0; i < 260; i++) tick();
    check_state("sat", 2, 6, 255);
    rand_in = 3'd1; tick(); check_state("sat_fill", 3, 70, 255);
    // Async reset between edges with a pending pop
    next_req = 1'b1;
    restart  = 1'b1;
    #1;
    check_state("async_rst", 0, 0, 0);
    #4;
    restart  = 1'b0;
    next_req = 1'b0;
    rand_in  = 3'd7;
    tick(); check_state("post_rst", 0, 0, 1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
